// File: rtl/lsu_bus_master_if.sv
// CPU-side request/response and word-addressed memory bus between the LSU and the memory/I-O manager.
interface lsu_bus_master_if;
  localparam int unsigned AW = 32;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_wdata;
  logic          resp_valid;
  logic [AW-1:0] resp_rdata;
  logic          resp_err;
  logic          stall;
  logic [AW-1:0] bus_addr;
  logic [AW-1:0] bus_wdata;
  logic          bus_memwrite;
  logic [AW-1:0] bus_rdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall, bus_addr, bus_wdata, bus_memwrite
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall, bus_addr, bus_wdata, bus_memwrite
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one byte/half/word access at a time, sub-word stores via read-modify-write.
// Optional feature: define ALIGN_CHECK_EN to reject misaligned accesses with resp_err.
module lsu_bus_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  lsu_bus_master_if.master lsu
);
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    lane_q, size_q;
  logic          signed_q;
  logic [15:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q, resp_valid_q, resp_err_q, bus_memwrite_q;
  logic [AW-1:0] resp_rdata_q, bus_addr_q, bus_wdata_q;
  logic          req_ready_d, resp_valid_d, resp_err_d, bus_memwrite_d;
  logic [AW-1:0] resp_rdata_d, bus_addr_d, bus_wdata_d;

  logic          accept, size_word, size_half, err_c, rd_done;
  logic [AW-1:0] aligned_addr, merged, extended;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign accept    = lsu.req_valid && req_ready_q;
  assign size_word = lsu.req_size[1];
  assign size_half = (lsu.req_size == 2'd1);
  assign rd_done   = (cnt_q == CW'(READ_LATENCY));

`ifdef ALIGN_CHECK_EN
  logic misalign;
  assign misalign = (size_half && lsu.req_addr[0]) || (size_word && (lsu.req_addr[1:0] != 2'b00));
  assign err_c    = misalign;
`else
  assign err_c    = 1'b0;
`endif

  // Offending low bits are cleared; with the alignment check on, those requests never reach the bus.
  always_comb begin
    aligned_addr = lsu.req_addr;
    if (size_word)      aligned_addr[1:0] = 2'b00;
    else if (size_half) aligned_addr[0]   = 1'b0;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    byte_v   = lsu.bus_rdata[{lane_q, 3'b000} +: 8];
    half_v   = lsu.bus_rdata[{lane_q[1], 4'b0000} +: 16];
    merged   = lsu.bus_rdata;
    if (size_q == 2'd0) merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
    else                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    case (size_q)
      2'd0:    extended = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
      2'd1:    extended = signed_q ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
      default: extended = lsu.bus_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (err_c)                              state_d = S_RESP;
          else if (lsu.req_write && !size_word)   state_d = S_RMW_RD;
          else if (lsu.req_write)                 state_d = S_WR;
          else                                    state_d = S_RD;
        end
      end
      S_RD:     if (rd_done) state_d = S_RESP;
      S_RMW_RD: if (rd_done) state_d = S_WR;
      S_WR:     state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    req_ready_d    = (state_d == S_IDLE);
    resp_valid_d   = (state_d == S_RESP);
    bus_memwrite_d = (state_d == S_WR);
    resp_err_d     = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (err_c) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            bus_addr_d = {2'b00, aligned_addr[AW-1:2]};
            if (lsu.req_write && size_word) bus_wdata_d = lsu.req_wdata;
          end
        end
      end
      S_RD:     if (rd_done) resp_rdata_d = extended;
      S_RMW_RD: if (rd_done) bus_wdata_d = merged;
      S_WR:     resp_rdata_d = '0;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      bus_memwrite_q <= 1'b0;
      resp_rdata_q   <= '0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      wdata_q        <= '0;
      cnt_q          <= '0;
    end else begin
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      bus_memwrite_q <= bus_memwrite_d;
      resp_rdata_q   <= resp_rdata_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      if (accept) begin
        lane_q   <= aligned_addr[1:0];
        size_q   <= lsu.req_size;
        signed_q <= lsu.req_signed;
        wdata_q  <= lsu.req_wdata[15:0];
        cnt_q    <= '0;
      end else if ((state_q == S_RD || state_q == S_RMW_RD) && !rd_done) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign lsu.req_ready    = req_ready_q;
  assign lsu.resp_valid   = resp_valid_q;
  assign lsu.resp_rdata   = resp_rdata_q;
  assign lsu.resp_err     = resp_err_q;
  assign lsu.bus_addr     = bus_addr_q;
  assign lsu.bus_wdata    = bus_wdata_q;
  assign lsu.bus_memwrite = bus_memwrite_q;
  assign lsu.stall        = lsu.req_valid && !req_ready_q;
endmodule
